// File: rtl/inst_encoder_if.sv
// Request and instruction-memory write bundle for inst_encoder.
// slave is the encoder's view; master is the request generator / memory model side.
interface inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_fmt;
    logic [6:0]        req_opcode;
    logic [2:0]        req_funct3;
    logic [6:0]        req_funct7;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [31:0]       req_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [1:0]        err_code;

    modport slave (
        input  req_valid, req_fmt, req_opcode, req_funct3, req_funct7,
               req_rd, req_rs1, req_rs2, req_imm, mem_ack,
        output req_ready, mem_we, mem_addr, mem_wdata, count, full, err, err_code
    );

    modport master (
        output req_valid, req_fmt, req_opcode, req_funct3, req_funct7,
               req_rd, req_rs1, req_rs2, req_imm, mem_ack,
        input  req_ready, mem_we, mem_addr, mem_wdata, count, full, err, err_code
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder and sequential instruction-memory writer.
// Define ENCODER_RANGE_CHECK_EN to enable immediate range/alignment checking.
module inst_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic           clk,
    input logic           rst,
    input logic           start,
    inst_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ENCODE, WRITE, FULL} state_t;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [ADDR_W:0] WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              accept;

    logic [2:0]  fmt_q;
    logic [6:0]  opcode_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [31:0] imm_q;

    logic [31:0] word;
    logic        bad_fmt;
    logic        range_err;
    logic        align_err;
    logic        is_shift;

    assign is_shift = (fmt_q == FMT_I) && (opcode_q == 7'b0010011) &&
                      ((funct3_q == 3'b001) || (funct3_q == 3'b101));

    always_comb begin
        word    = '0;
        bad_fmt = 1'b0;
        case (fmt_q)
            FMT_R: word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
            FMT_I: word = is_shift ? {funct7_q, imm_q[4:0], rs1_q, funct3_q, rd_q, opcode_q}
                                   : {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
            FMT_S: word = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
            FMT_B: word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                           imm_q[4:1], imm_q[11], opcode_q};
            FMT_U: word = {imm_q[31:12], rd_q, opcode_q};
            FMT_J: word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode_q};
            default: bad_fmt = 1'b1;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = imm_q;

    always_comb begin
        range_err = 1'b0;
        align_err = 1'b0;
        case (fmt_q)
            FMT_I: begin
                if (is_shift) range_err = (simm < 0) || (simm > 31);
                else          range_err = (simm < -2048) || (simm > 2047);
            end
            FMT_S: range_err = (simm < -2048) || (simm > 2047);
            FMT_B: begin
                range_err = (simm < -4096) || (simm > 4094);
                align_err = imm_q[0];
            end
            FMT_J: begin
                range_err = (simm < -1048576) || (simm > 1048574);
                align_err = imm_q[0];
            end
            FMT_U: align_err = |imm_q[11:0];
            default: ;
        endcase
    end
`else
    assign range_err = 1'b0;
    assign align_err = 1'b0;
`endif

    // start overrides every state and blocks a same-cycle request
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        code_d  = code_q;
        accept  = 1'b0;
        if (start) begin
            state_d = IDLE;
            ready_d = 1'b1;
            we_d    = 1'b0;
            addr_d  = BASE_ADDR;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_d = 1'b1;
                    if (bus.req_valid && ready_q) begin
                        accept  = 1'b1;
                        ready_d = 1'b0;
                        state_d = ENCODE;
                    end
                end
                ENCODE: begin
                    if (bad_fmt || range_err || align_err) begin
                        err_d   = 1'b1;
                        code_d  = bad_fmt ? 2'b11 : (range_err ? 2'b01 : 2'b10);
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = word;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        we_d    = 1'b0;
                        addr_d  = addr_q + 1'b1;
                        count_d = count_q + 1'b1;
                        if (count_d == WORDS) begin
                            full_d  = 1'b1;
                            state_d = FULL;
                        end else begin
                            ready_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                FULL: begin
                    ready_d = 1'b0;
                    full_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fmt_q    <= '0;
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
        end else if (accept) begin
            fmt_q    <= bus.req_fmt;
            opcode_q <= bus.req_opcode;
            funct3_q <= bus.req_funct3;
            funct7_q <= bus.req_funct7;
            rd_q     <= bus.req_rd;
            rs1_q    <= bus.req_rs1;
            rs2_q    <= bus.req_rs2;
            imm_q    <= bus.req_imm;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder, built with a 4-word memory
// whose base address of 2 makes the write sequence wrap 2,3,0,1.
module tb_inst_encoder;
    localparam int         AW   = 2;
    localparam logic [1:0] BASE = 2'd2;

    logic clk;
    logic rst;
    logic start;
    int   checks;
    int   failures;

    inst_encoder_if #(.ADDR_W(AW)) bus ();

    inst_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for req_ready, then presents one request for a single edge
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL send_ready_timeout: req_ready=%b required 1", bus.req_ready);
        end
        bus.req_fmt    = fmt;
        bus.req_opcode = op;
        bus.req_funct3 = f3;
        bus.req_funct7 = f7;
        bus.req_rd     = rd;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        bus.req_imm    = imm;
        bus.req_valid  = 1'b1;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b want 0", bus.req_ready); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== BASE) begin failures++; $display("[TB] FAIL reset_addr: got %0d want %0d", bus.mem_addr, BASE); end
        checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_wdata: got %h want 0", bus.mem_wdata); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %b want 0", bus.full); end
        checks++; if (bus.err !== 1'b0 || bus.err_code !== 2'b00) begin failures++; $display("[TB] FAIL reset_err: got %b/%b want 0/00", bus.err, bus.err_code); end
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL ready_after_release: got %b want 0", bus.req_ready); end
        tick();
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL ready_rise: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_i_format();
        pulse_start();
        send(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("[TB] FAIL i_we: got %b want 1", bus.mem_we); end
        checks++; if (bus.mem_addr !== BASE) begin failures++; $display("[TB] FAIL i_addr: got %0d want %0d", bus.mem_addr, BASE); end
        checks++; if (bus.mem_wdata !== 32'h00500093) begin failures++; $display("[TB] FAIL i_wdata: got %h want 00500093", bus.mem_wdata); end
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL i_ready_busy: got %b want 0", bus.req_ready); end
        tick();
        checks++; if (bus.mem_we !== 1'b0 || bus.count !== 3'd1) begin failures++; $display("[TB] FAIL i_done: got we=%b count=%0d want 0/1", bus.mem_we, bus.count); end
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL i_ready_again: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_shift();
        pulse_start();
        send(3'd1, 7'b0010011, 3'b101, 7'b0100000, 5'd3, 5'd3, 5'd0, 32'd4);
        tick();
        checks++; if (bus.mem_wdata !== 32'h4041D193 || bus.mem_we !== 1'b1) begin failures++; $display("[TB] FAIL shift_wdata: got %h we=%b want 4041d193/1", bus.mem_wdata, bus.mem_we); end
        tick();
        send(3'd1, 7'b0010011, 3'b101, 7'b0100000, 5'd3, 5'd3, 5'd0, 32'd40);
        tick();
`ifdef ENCODER_RANGE_CHECK_EN
        checks++; if (bus.err !== 1'b1 || bus.err_code !== 2'b01) begin failures++; $display("[TB] FAIL shift_range_err: got %b/%b want 1/01", bus.err, bus.err_code); end
        checks++; if (bus.mem_we !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL shift_range_nowrite: got we=%b ready=%b want 0/1", bus.mem_we, bus.req_ready); end
        checks++; if (bus.count !== 3'd1) begin failures++; $display("[TB] FAIL shift_range_count: got %0d want 1", bus.count); end
`else
        checks++; if (bus.mem_wdata !== 32'h4081D193 || bus.err !== 1'b0) begin failures++; $display("[TB] FAIL shift_trunc: got %h err=%b want 4081d193/0", bus.mem_wdata, bus.err); end
        tick();
        checks++; if (bus.count !== 3'd2) begin failures++; $display("[TB] FAIL shift_trunc_count: got %0d want 2", bus.count); end
`endif
    endtask

    task automatic test_branch();
        int         written;
        logic [1:0] exp_addr;
        pulse_start();
        send(3'd3, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8);
        tick();
        checks++; if (bus.mem_wdata !== 32'hFE208CE3) begin failures++; $display("[TB] FAIL b_wdata: got %h want fe208ce3", bus.mem_wdata); end
        tick();
        written = 1;
        send(3'd3, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd7);
        tick();
`ifdef ENCODER_RANGE_CHECK_EN
        checks++; if (bus.err !== 1'b1 || bus.err_code !== 2'b10 || bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL b_align: got err=%b code=%b we=%b want 1/10/0", bus.err, bus.err_code, bus.mem_we); end
`else
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'hFE208CE3) begin failures++; $display("[TB] FAIL b_trunc: got we=%b data=%h want 1/fe208ce3", bus.mem_we, bus.mem_wdata); end
        tick();
        written = 2;
`endif
        send(3'd3, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8);
        tick();
        exp_addr = BASE + 2'(written);
        checks++; if (bus.mem_addr !== exp_addr || bus.mem_we !== 1'b1) begin failures++; $display("[TB] FAIL b_next_addr: got %0d we=%b want %0d/1", bus.mem_addr, bus.mem_we, exp_addr); end
        tick();
    endtask

    task automatic test_jump();
        pulse_start();
        send(3'd5, 7'b1101111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        checks++; if (bus.mem_wdata !== 32'h001000EF) begin failures++; $display("[TB] FAIL j_wdata: got %h want 001000ef", bus.mem_wdata); end
        tick();
        send(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
`ifdef ENCODER_RANGE_CHECK_EN
        checks++; if (bus.err_code !== 2'b01 || bus.count !== 3'd1 || bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL i_range: got code=%b count=%0d we=%b want 01/1/0", bus.err_code, bus.count, bus.mem_we); end
`else
        checks++; if (bus.mem_wdata !== 32'h80000093 || bus.err !== 1'b0) begin failures++; $display("[TB] FAIL i_trunc: got %h err=%b want 80000093/0", bus.mem_wdata, bus.err); end
        tick();
`endif
        send(3'd6, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        tick();
        checks++; if (bus.err !== 1'b1 || bus.err_code !== 2'b11 || bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL bad_fmt: got err=%b code=%b we=%b want 1/11/0", bus.err, bus.err_code, bus.mem_we); end
    endtask

    task automatic test_backpressure();
        pulse_start();
        bus.mem_ack = 1'b0;
        send(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== BASE || bus.mem_wdata !== 32'h00500093 ||
                bus.req_ready !== 1'b0 || bus.count !== 3'd0) begin
                failures++;
                $display("[TB] FAIL bp_hold%0d: got we=%b addr=%0d data=%h ready=%b count=%0d want 1/%0d/00500093/0/0",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.req_ready, bus.count, BASE);
            end
        end
        bus.mem_ack = 1'b1;
        tick();
        checks++; if (bus.mem_we !== 1'b0 || bus.count !== 3'd1) begin failures++; $display("[TB] FAIL bp_release: got we=%b count=%0d want 0/1", bus.mem_we, bus.count); end
        tick();
        tick();
        checks++; if (bus.count !== 3'd1) begin failures++; $display("[TB] FAIL idle_ack_ignored: got count=%0d want 1", bus.count); end
    endtask

    task automatic test_start_priority();
        pulse_start();
        bus.req_fmt = 3'd1; bus.req_opcode = 7'b0010011; bus.req_funct3 = 3'b000;
        bus.req_rd = 5'd1; bus.req_rs1 = 5'd0; bus.req_imm = 32'd5;
        start = 1'b1;
        bus.req_valid = 1'b1;
        tick();
        start = 1'b0;
        bus.req_valid = 1'b0;
        tick();
        tick();
        checks++; if (bus.mem_we !== 1'b0 || bus.count !== 3'd0) begin failures++; $display("[TB] FAIL start_blocks_req: got we=%b count=%0d want 0/0", bus.mem_we, bus.count); end
        bus.mem_ack = 1'b0;
        send(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        pulse_start();
        checks++; if (bus.mem_we !== 1'b0 || bus.count !== 3'd0 || bus.mem_addr !== BASE) begin failures++; $display("[TB] FAIL start_abort: got we=%b count=%0d addr=%0d want 0/0/%0d", bus.mem_we, bus.count, bus.mem_addr, BASE); end
        bus.mem_ack = 1'b1;
    endtask

    task automatic test_full();
        logic [1:0]  exp_addr;
        logic [31:0] exp_word;
        pulse_start();
        send(3'd7, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            send(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i));
            tick();
            exp_addr = BASE + 2'(i);
            exp_word = 32'h00000093 | (32'(i) << 20);
            checks++;
            if (bus.mem_addr !== exp_addr || bus.mem_wdata !== exp_word || bus.mem_we !== 1'b1) begin
                failures++;
                $display("[TB] FAIL full_write%0d: got addr=%0d data=%h we=%b want %0d/%h/1", i, bus.mem_addr, bus.mem_wdata, bus.mem_we, exp_addr, exp_word);
            end
            tick();
        end
        checks++; if (bus.full !== 1'b1 || bus.req_ready !== 1'b0 || bus.count !== 3'd4) begin failures++; $display("[TB] FAIL full_state: got full=%b ready=%b count=%0d want 1/0/4", bus.full, bus.req_ready, bus.count); end
        bus.req_valid = 1'b1;
        repeat (5) tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_we !== 1'b0 || bus.count !== 3'd4 || bus.full !== 1'b1) begin failures++; $display("[TB] FAIL full_blocks: got we=%b count=%0d full=%b want 0/4/1", bus.mem_we, bus.count, bus.full); end
        pulse_start();
        checks++; if (bus.count !== 3'd0 || bus.mem_addr !== BASE || bus.full !== 1'b0) begin failures++; $display("[TB] FAIL restart: got count=%0d addr=%0d full=%b want 0/%0d/0", bus.count, bus.mem_addr, bus.full, BASE); end
        checks++; if (bus.err !== 1'b0 || bus.err_code !== 2'b00) begin failures++; $display("[TB] FAIL restart_err: got %b/%b want 0/00", bus.err, bus.err_code); end
        tick();
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL restart_ready: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        bus.mem_ack = 1'b0;
        send(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0 || bus.req_ready !== 1'b0 || bus.mem_addr !== BASE) begin failures++; $display("[TB] FAIL reset_mid: got we=%b data=%h ready=%b addr=%0d want 0/0/0/%0d", bus.mem_we, bus.mem_wdata, bus.req_ready, bus.mem_addr, BASE); end
        tick();
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        checks = 0;
        failures = 0;
        bus.req_valid = 1'b0;
        bus.req_fmt = '0;
        bus.req_opcode = '0;
        bus.req_funct3 = '0;
        bus.req_funct7 = '0;
        bus.req_rd = '0;
        bus.req_rs1 = '0;
        bus.req_rs2 = '0;
        bus.req_imm = '0;
        bus.mem_ack = 1'b1;
        test_reset();
        test_i_format();
        test_shift();
        test_branch();
        test_jump();
        test_backpressure();
        test_start_priority();
        test_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Program writer for the RV32I pipeline's instruction memory: accepts field-level instruction requests (format, opcode, funct, register numbers, byte-offset immediate) over a valid/ready handshake. Each request is encoded into a 32-bit RV32I instruction word with immediate range and alignment checks. The word is written to sequential instruction-memory addresses over a write/acknowledge port. It is the encoding counterpart of the decode stage and is used for boot-time program loading and self-test.

## Interface
- `ADDR_W`, 10: instruction-memory word-address width.
- `BASE_ADDR`, 0: first word address written after reset/`start`.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: pulse; restarts program at `BASE_ADDR`, clears `count`, `err`, `err_code`.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_fmt` in 3: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J; 6–7 invalid.
- `req_opcode` in 7, `req_funct3` in 3, `req_funct7` in 7.
- `req_rd`, `req_rs1`, `req_rs2` in 5.
- `req_imm` in 32: signed byte offset, not pre-shifted; U-format carries the full value.
- `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out 32, `mem_ack` in 1: memory write port.
- `count` out ADDR_W+1: words written since `start`.
- `full` out 1: 2^ADDR_W words written.
- `err` out 1 (sticky), `err_code` out 2 (01 range, 10 alignment, 11 invalid format; last error wins).

## Operation
- FSM states: IDLE, ENCODE, WRITE, FULL.
- IDLE: `req_ready`=1. On `req_valid`, latch all fields and go to ENCODE.
- ENCODE: build the word and run the checks.
  - Check fails: set `err`/`err_code`, drop the word, return to IDLE. Address and count are unchanged.
  - Check passes: go to WRITE.
- Encoding (bits MSB→LSB):
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - I-shift (opcode 0010011, funct3 001/101): funct7|imm[4:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Checks:
  - I/S: −2048..2047.
  - I-shift: 0..31.
  - B: −4096..4094, imm[0]=0.
  - J: −2^20..2^20−2, imm[0]=0.
  - U: imm[11:0]=0 (alignment).
  - R: imm ignored.
  - Out-of-range → 01; misaligned → 10; fmt 6/7 → 11.
- WRITE: `mem_we`=1, with `mem_addr` and `mem_wdata` held stable until `mem_ack` is sampled high.
  - On ack: `mem_we`→0, address+1, `count`+1.
  - Next state is IDLE, or FULL when `count` reaches 2^ADDR_W.
- FULL: `req_ready`=0, `full`=1; only `start` or `rst` leaves it.
- Address wraps modulo 2^ADDR_W from `BASE_ADDR`; FULL prevents overwrite.

## Timing
- Reset values: `req_ready`=0, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `count`=0, `full`=0, `err`=0, `err_code`=00. State is IDLE; `req_ready` rises the cycle after `rst` deasserts.
- Accept at edge 0 → ENCODE → `mem_we` registered high after edge 1.
- With `mem_ack` tied high: `mem_we` is high one cycle, and the next accept is at edge 3 (3 cycles/word).
- `req_ready` is 0 in ENCODE, WRITE and FULL.
- Failed check: `err` is high after edge 1, and `req_ready` is high again after edge 1.
- `mem_ack` while `mem_we`=0 is ignored.
- `start` has priority over everything, including a simultaneous `req_valid`, which is not accepted.
  - Mid-WRITE: abort; `mem_we`=0 after that edge; no count increment.
- `rst` mid-operation: immediate return to reset values.

## Configuration
- `ENCODER_RANGE_CHECK_EN` defined: range and alignment checks as above.
- Undefined:
  - Immediates are silently truncated to their field bits and always written.
  - `err_code` 01/10 are never produced; fmt 6/7 is still flagged as 11.

## Test plan
- I-format: opcode 0010011, f3 000, rd 1, rs1 0, imm 5 → `mem_wdata`=0x00500093 at addr 0; `count`=1.
- I-shift: f3 101, funct7 0100000, rd/rs1 3, imm 4 → 0x4041D193. Out-of-range: same with imm 40 → `err`=1, code 01, no write.
- B-format: opcode 1100011, rs1 1, rs2 2, imm −8 → 0xFE208CE3. Misaligned: imm −7 → code 10, and the next valid word lands at the unchanged address.
- J-format: opcode 1101111, rd 1, imm 2048 → 0x001000EF. Out-of-range: I-format imm 2048 → code 01, `count` unchanged.
- Backpressure: `mem_ack` low 5 cycles → `mem_we`/addr/data stable, `req_ready`=0; ack → `mem_we`=0 next cycle, count+1.
- Full and restart with ADDR_W=2: write 4 words → `full`=1, `req_ready`=0, 5th request not accepted. `start` → `count`=0, `mem_addr`=BASE_ADDR, `full`=0, `err`=0.
